// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, parity selectors
// and the oversampling factor that turns prescale into a bit period.
package uart_pkg;

   localparam int OVERSAMPLE  = 8;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Bit period in clk cycles; a prescale of zero is treated as one.
   function automatic logic [18:0] bit_period(input logic [15:0] prescale);
      logic [15:0] eff;
      eff = (prescale == 16'd0) ? 16'd1 : prescale;
      return 19'(eff) * 19'(OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of every bit period,
// held at zero while disabled and cleared by restart at frame start.
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        restart,
   input  logic [15:0] prescale,
   output logic        tick
);

   logic [18:0] cnt_q;
   logic [18:0] cnt_d;
   logic [18:0] period_m1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      period_m1 = bit_period(prescale) - 19'd1;
      tick      = enable && (cnt_q == period_m1);
      cnt_d     = cnt_q + 19'd1;
      if (restart || !enable || tick) begin
         cnt_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with an AXI-Stream style input: start bit,
// DATA_WIDTH bits LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = PARITY_NONE,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [15:0]           prescale,
   output logic                  txd,
   output logic                  busy,
   output logic                  frame_done
);

   if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_data_width
      $error("uart_tx_param: DATA_WIDTH must be in 5..16");
   end
   if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity_mode
      $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(DATA_WIDTH);
   localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, bits_sent;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  parity_q, parity_d;
   logic [15:0]           prescale_q, prescale_d;
   logic                  txd_q, txd_d;
   logic                  ready_q;
   logic                  restart;
   logic                  tick;

   uart_baud_tick u_baud_tick (
      .clk      (clk),
      .rst      (rst),
      .enable   (busy),
      .restart  (restart),
      .prescale (prescale_q),
      .tick     (tick)
   );

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      prescale_d = prescale_q;
      restart    = 1'b0;
      frame_done = 1'b0;
      bits_sent  = bit_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (s_axis_tvalid && ready_q) begin
               state_d    = START;
               data_d     = s_axis_tdata;
               prescale_d = prescale;
               parity_d   = (^s_axis_tdata) ^ (PARITY_MODE == PARITY_ODD);
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               restart    = 1'b1;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               data_d    = data_q >> 1;
               bit_cnt_d = bits_sent;
               if (bits_sent == ALL_BITS) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d    = IDLE;
                  stop_cnt_d = 1'b0;
                  frame_done = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the next state so txd leaves a flop and cannot glitch.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = data_d[0];
         PARITY:  txd_d = parity_d;
         default: txd_d = 1'b1;
      endcase
   end

   // NOTE: ready has its own flop so it stays low through reset without any path from tvalid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         data_q     <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         prescale_q <= '0;
         txd_q      <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         prescale_q <= prescale_d;
         txd_q      <= txd_d;
         ready_q    <= (state_d == IDLE);
      end
   end

   assign s_axis_tready = ready_q;
   assign busy          = (state_q != IDLE);
   assign txd           = txd_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised self-checking bench: five transmitter configurations compared
// cycle by cycle against a frame-level reference model.
module tb_uart_tx_param;

   localparam int NCFG = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tdata      [NCFG];
   logic        tvalid     [NCFG];
   logic        tready     [NCFG];
   logic [15:0] prescale   [NCFG];
   logic        txd        [NCFG];
   logic        busy       [NCFG];
   logic        frame_done [NCFG];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata[0][7:0]), .s_axis_tvalid(tvalid[0]),
      .s_axis_tready(tready[0]), .prescale(prescale[0]), .txd(txd[0]),
      .busy(busy[0]), .frame_done(frame_done[0]));
   uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata[1][7:0]), .s_axis_tvalid(tvalid[1]),
      .s_axis_tready(tready[1]), .prescale(prescale[1]), .txd(txd[1]),
      .busy(busy[1]), .frame_done(frame_done[1]));
   uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata[2][7:0]), .s_axis_tvalid(tvalid[2]),
      .s_axis_tready(tready[2]), .prescale(prescale[2]), .txd(txd[2]),
      .busy(busy[2]), .frame_done(frame_done[2]));
   uart_tx_param #(.DATA_WIDTH(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dut3 (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
      .s_axis_tready(tready[3]), .prescale(prescale[3]), .txd(txd[3]),
      .busy(busy[3]), .frame_done(frame_done[3]));
   uart_tx_param #(.DATA_WIDTH(5), .PARITY_MODE(2), .STOP_BITS(2)) u_dut4 (
      .clk(clk), .rst(rst), .s_axis_tdata(tdata[4][4:0]), .s_axis_tvalid(tvalid[4]),
      .s_axis_tready(tready[4]), .prescale(prescale[4]), .txd(txd[4]),
      .busy(busy[4]), .frame_done(frame_done[4]));

   function automatic int cfg_dw(input int k);
      case (k)
         3:       return 16;
         4:       return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_pm(input int k);
      case (k)
         1:       return 1;
         2, 4:    return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_sb(input int k);
      return (k == 2 || k == 4) ? 2 : 1;
   endfunction

   // Reference frame: bit i of v is the i-th bit on the line; returns the bit count.
   function automatic int model_frame(input int k, input logic [15:0] d, output logic [31:0] v);
      int   n;
      logic par;
      v   = '0;
      n   = 1;
      par = 1'b0;
      for (int i = 0; i < cfg_dw(k); i++) begin
         v[n] = d[i];
         par  = par ^ d[i];
         n++;
      end
      if (cfg_pm(k) != 0) begin
         v[n] = (cfg_pm(k) == 2) ? ~par : par;
         n++;
      end
      for (int s = 0; s < cfg_sb(k); s++) begin
         v[n] = 1'b1;
         n++;
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns just after the handshake posedge.
   task automatic do_handshake(input int k, input logic [15:0] d, input logic [15:0] p);
      int w;
      w         = 0;
      tdata[k]  = d;
      prescale[k] = p;
      tvalid[k] = 1'b1;
      while (tready[k] !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      check("hs_timeout", 32'(w >= 64), 32'd0);
      @(posedge clk);
   endtask

   // Samples every cycle of one frame, then the idle cycle that follows it.
   task automatic capture(input int k, input logic [15:0] d, input logic [15:0] p,
                          input bit hold, input logic [15:0] next_d, input logic [15:0] next_p,
                          output logic [31:0] obs_bits, output int fd_cycle);
      logic [31:0] exp_bits;
      int nbits, per, total, txd_err, st_err, fd_n;
      nbits   = model_frame(k, d, exp_bits);
      per     = ((p == 16'd0) ? 1 : int'(p)) * 8;
      total   = nbits * per;
      txd_err = 0;
      st_err  = 0;
      fd_n    = 0;
      fd_cycle = -1;
      obs_bits = '0;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (hold) begin
               tdata[k]    = next_d;
               prescale[k] = next_p;
            end else begin
               tvalid[k]   = 1'b0;
               tdata[k]    = 16'($urandom);
               prescale[k] = 16'($urandom_range(0, 7));
            end
         end
         if (txd[k] !== exp_bits[c / per]) txd_err++;
         if (busy[k] !== 1'b1 || tready[k] !== 1'b0) st_err++;
         if (frame_done[k] === 1'b1) begin
            fd_n++;
            if (fd_cycle < 0) fd_cycle = c;
         end
         if (c % per == per / 2) obs_bits[c / per] = txd[k];
      end
      check($sformatf("cfg%0d_txd_wave", k), txd_err, 0);
      check($sformatf("cfg%0d_bits", k), obs_bits, exp_bits);
      check($sformatf("cfg%0d_busy_ready", k), st_err, 0);
      check($sformatf("cfg%0d_fd_cycle", k), fd_cycle, total - 1);
      check($sformatf("cfg%0d_fd_count", k), fd_n, 1);
      @(negedge clk);
      check($sformatf("cfg%0d_gap_busy", k), busy[k], 1'b0);
      check($sformatf("cfg%0d_gap_txd", k), txd[k], 1'b1);
      check($sformatf("cfg%0d_gap_ready", k), tready[k], 1'b1);
      check($sformatf("cfg%0d_gap_fd", k), frame_done[k], 1'b0);
   endtask

   initial begin
      logic [31:0] obs;
      int          fd;
      int          k, bad;
      logic [15:0] d, d2, p, p2;

      for (int i = 0; i < NCFG; i++) begin
         tdata[i]    = '0;
         tvalid[i]   = 1'b0;
         prescale[i] = '0;
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
         check($sformatf("rst%0d_txd", i), txd[i], 1'b1);
         check($sformatf("rst%0d_busy", i), busy[i], 1'b0);
         check($sformatf("rst%0d_ready", i), tready[i], 1'b0);
         check($sformatf("rst%0d_fd", i), frame_done[i], 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) check($sformatf("rel%0d_ready", i), tready[i], 1'b1);

      // 16-bit word, prescale 6: 18 bits of 48 cycles.
      do_handshake(3, 16'hBEEF, 16'd6);
      capture(3, 16'hBEEF, 16'd6, 1'b0, 16'd0, 16'd0, obs, fd);
      check("beef_seq", obs, 32'({1'b1, 16'hBEEF, 1'b0}));
      check("beef_len", fd + 1, 864);

      // Even and odd parity on 8'hA5.
      do_handshake(1, 16'h00A5, 16'd2);
      capture(1, 16'h00A5, 16'd2, 1'b0, 16'd0, 16'd0, obs, fd);
      check("even_parity", obs[9], 1'b0);
      check("even_len", fd + 1, 176);
      do_handshake(2, 16'h00A5, 16'd1);
      capture(2, 16'h00A5, 16'd1, 1'b0, 16'd0, 16'd0, obs, fd);
      check("odd_parity", obs[9], 1'b1);
      check("two_stop_len", fd + 1, 96);

      // Prescale zero behaves as one.
      do_handshake(0, 16'h003C, 16'd0);
      capture(0, 16'h003C, 16'd0, 1'b0, 16'd0, 16'd0, obs, fd);
      check("presc0_len", fd + 1, 80);

      // Back-to-back words with tvalid held high.
      do_handshake(0, 16'h0055, 16'd1);
      capture(0, 16'h0055, 16'd1, 1'b1, 16'h000F, 16'd1, obs, fd);
      do_handshake(0, 16'h000F, 16'd1);
      capture(0, 16'h000F, 16'd1, 1'b0, 16'd0, 16'd0, obs, fd);
      check("b2b_second", obs, 32'({1'b1, 8'h0F, 1'b0}));

      // Reset in the middle of data bit 5, then a clean frame.
      do_handshake(0, 16'h00C3, 16'd1);
      @(negedge clk);
      tvalid[0] = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_busy", busy[0], 1'b1);
      check("mid_txd", txd[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_txd", txd[0], 1'b1);
      check("abort_busy", busy[0], 1'b0);
      check("abort_ready", tready[0], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rel_ready", tready[0], 1'b1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      check("no_resume", bad, 0);
      do_handshake(0, 16'h00C3, 16'd1);
      capture(0, 16'h00C3, 16'd1, 1'b0, 16'd0, 16'd0, obs, fd);
      check("after_rst_c3", obs, 32'({1'b1, 8'hC3, 1'b0}));

      // Random words, prescales and configurations.
      for (int i = 0; i < 16; i++) begin
         k = $urandom_range(0, NCFG - 1);
         d = 16'($urandom);
         p = 16'($urandom_range(0, 3));
         do_handshake(k, d, p);
         if (i % 4 == 3) begin
            d2 = 16'($urandom);
            p2 = 16'($urandom_range(0, 3));
            capture(k, d, p, 1'b1, d2, p2, obs, fd);
            do_handshake(k, d2, p2);
            capture(k, d2, p2, 1'b0, 16'd0, 16'd0, obs, fd);
         end else begin
            capture(k, d, p, 1'b0, 16'd0, 16'd0, obs, fd);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload bits per frame; legal range 5..16.
REQ-002 Parameter PARITY_MODE, default 0, SHALL select the parity bit: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-004 Port clk  input  1  SHALL be the single rising-edge clock for all logic.
REQ-005 Port rst  input  1  SHALL be the synchronous, active-low reset.
REQ-006 Port s_axis_tdata  input  DATA_WIDTH  SHALL carry the payload word.
REQ-007 Port s_axis_tvalid  input  1  SHALL indicate that the payload is valid.
REQ-008 Port s_axis_tready  output  1  SHALL indicate that the block can accept a word.
REQ-009 Port prescale  input  16  SHALL set the bit period to prescale*8 clk cycles.
REQ-010 Port txd  output  1  SHALL be the serial line, idle high.
REQ-011 Port busy  output  1  SHALL be high while a frame is in progress.
REQ-012 Port frame_done  output  1  SHALL pulse high for one cycle on the last cycle of the final stop bit.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions SHALL be: IDLE->START on handshake; START->DATA; DATA->PARITY when PARITY_MODE!=0, else DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-015 s_axis_tready SHALL equal (state==IDLE), with no combinational path from s_axis_tvalid.
REQ-016 Handshake SHALL be tvalid&&tready at a clk edge; tdata and prescale SHALL be latched at that edge.
REQ-017 txd SHALL go low on the cycle after the handshake edge, a 1-cycle latency.
REQ-018 Each bit SHALL last exactly max(prescale_latched,1)*8 cycles; prescale=0 SHALL behave as 1.
REQ-019 Data SHALL be sent LSB first, all DATA_WIDTH bits.
REQ-020 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide and SHALL never wrap before DATA_WIDTH bits are sent, for any legal DATA_WIDTH including 16.
REQ-021 The prescale counter SHALL be 19 bits wide so that 65535*8 cannot overflow.
REQ-022 The parity bit SHALL be XOR of the data for even parity and its inverse for odd parity.
REQ-023 STOP SHALL drive txd high for STOP_BITS bit periods.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 A total frame SHALL last (1+DATA_WIDTH+(PARITY_MODE!=0)+STOP_BITS)*bit_period cycles.
REQ-026 If tvalid is high during frame_done, the next handshake SHALL occur on the cycle after frame_done, with no idle gap beyond one cycle.
REQ-027 A change of prescale or tdata mid-frame SHALL NOT affect the current frame.

Reset
REQ-028 While rst==0 at a clk edge: state=IDLE, txd=1, busy=0, s_axis_tready=0, frame_done=0, all counters=0.
REQ-029 After rst rises, s_axis_tready SHALL assert on the first edge with rst high.
REQ-030 Reset asserted mid-frame SHALL abort the frame and drive txd high on the next edge; no partial frame SHALL resume.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding, the PARITY_NONE/EVEN/ODD constants and the OVERSAMPLE=8 constant.
REQ-032 A sub-module uart_baud_tick SHALL generate a one-cycle tick every max(prescale,1)*8 cycles, restartable on frame start.
REQ-033 Parameter legality SHALL be checked at elaboration, with an error on an illegal value.

Verification
REQ-034 DATA_WIDTH=16, PARITY_MODE=0, STOP_BITS=1, prescale=6, tdata=16'hBEEF -> 18 bits of 48 cycles each (864 cycles); bit sequence 0,1111011101111101,1; frame_done at cycle 864.
REQ-035 DATA_WIDTH=8, PARITY_MODE=1 (even), tdata=8'hA5 -> parity bit 0; PARITY_MODE=2 (odd) -> parity bit 1; frame length 11 bits.
REQ-036 STOP_BITS=2, prescale=1 -> stop high for 16 cycles; busy drops on the edge after frame_done.
REQ-037 tvalid held high with two words 8'h55 then 8'h0F -> second start bit begins 1 cycle after the first frame_done; txd never glitches low in between.
REQ-038 rst=0 asserted in DATA bit 5 -> next edge txd=1, busy=0; after release, a new word 8'hC3 transmits correctly.
REQ-039 prescale=0 -> 8-cycle bits, identical to prescale=1.
